// File: rtl/r30_field_pkg.sv
// Shared constants and helpers for the Rule 30 field engine.
package r30_field_pkg;

    // Value read for cells beyond either edge of the field.
    localparam logic zero_bound = 1'b0;

    // Counter width able to hold 0..d, never narrower than one bit.
    function automatic int cnt_width(input int d);
        if (d < 1) begin
            return 1;
        end
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/r30_step.sv
// One Rule 30 generation over an N-cell field with zero-valued edges.
module r30_step
    import r30_field_pkg::*;
#(
    parameter int N = 128
) (
    input  logic [N-1:0] cur,
    output logic [N-1:0] nxt
);

    // ext[i+1] holds cur[i]; ext[0] and ext[N+1] are the fixed edge cells.
    logic [N+1:0] ext;

    assign ext = {zero_bound, cur, zero_bound};

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign nxt[i] = ext[i+2] ^ (ext[i+1] | ext[i]);
    end

endmodule

// File: rtl/r30_field.sv
// Runs D Rule 30 generations on a captured seed and reports the result with a done pulse.
module r30_field
    import r30_field_pkg::*;
#(
    parameter int N = 128,
    parameter int D = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] seed,
    output logic [N-1:0] final_state,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(D);

    logic [N-1:0]  state;
    logic [N-1:0]  nxt;
    logic [CW-1:0] cnt;

    r30_step #(
        .N (N)
    ) u_step (
        .cur (state),
        .nxt (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= '0;
            final_state <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                state <= nxt;
                cnt   <= cnt - CW'(1);
                // Last generation: publish it and free the engine for a new start.
                if (cnt == CW'(1)) begin
                    final_state <= nxt;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
            end else if (start) begin
                state <= seed;
                cnt   <= CW'(D);
                if (D == 0) begin
                    final_state <= seed;
                    done        <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_r30_field.sv
// Directed bench for r30_field across D = 0, 1, 2 and 256 with a 128-cell field.
module tb_r30_field;

    localparam int N = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         st0, st1, st2, st256;
    logic [N-1:0] sd0, sd1, sd2, sd256;
    logic [N-1:0] fs0, fs1, fs2, fs256;
    logic         b0, b1, b2, b256;
    logic         dn0, dn1, dn2, dn256;

    int checks   = 0;
    int failures = 0;

    r30_field #(.N(N), .D(0)) u_d0 (
        .clk (clk), .rst_n (rst_n), .start (st0), .seed (sd0),
        .final_state (fs0), .busy (b0), .done (dn0)
    );
    r30_field #(.N(N), .D(1)) u_d1 (
        .clk (clk), .rst_n (rst_n), .start (st1), .seed (sd1),
        .final_state (fs1), .busy (b1), .done (dn1)
    );
    r30_field #(.N(N), .D(2)) u_d2 (
        .clk (clk), .rst_n (rst_n), .start (st2), .seed (sd2),
        .final_state (fs2), .busy (b2), .done (dn2)
    );
    r30_field #(.N(N), .D(256)) u_d256 (
        .clk (clk), .rst_n (rst_n), .start (st256), .seed (sd256),
        .final_state (fs256), .busy (b256), .done (dn256)
    );

    // Reference model: look up each neighbourhood {L,C,R} in the rule number 30.
    function automatic logic [N-1:0] gold(input logic [N-1:0] s, input int gens);
        logic [N-1:0] cur;
        logic [N-1:0] nx;
        logic [2:0]   p;
        logic [7:0]   rule;
        rule = 8'd30;
        cur  = s;
        for (int g = 0; g < gens; g++) begin
            for (int i = 0; i < N; i++) begin
                p[2]  = (i == N - 1) ? 1'b0 : cur[i+1];
                p[1]  = cur[i];
                p[0]  = (i == 0) ? 1'b0 : cur[i-1];
                nx[i] = rule[p];
            end
            cur = nx;
        end
        return cur;
    endfunction

    function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st0 = 0; st1 = 0; st2 = 0; st256 = 0;
        sd0 = '0; sd1 = '0; sd2 = '0; sd256 = '0;
        step();
        step();
        checks++;
        if ({fs0, fs1, fs2, fs256} !== '0) begin
            failures++;
            $display("FAIL reset_final got=%h exp=0", {fs0, fs1, fs2, fs256});
        end
        checks++;
        if ({b0, b1, b2, b256, dn0, dn1, dn2, dn256} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000000",
                     {b0, b1, b2, b256, dn0, dn1, dn2, dn256});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_d1();
        logic [N-1:0] exp;
        exp = bits3(65, 64, 63);
        sd1 = bits3(64, -1, -1);
        st1 = 1'b1;
        step();
        st1 = 1'b0;
        checks++;
        if ({b1, dn1} !== 2'b10) begin
            failures++;
            $display("FAIL d1_accept busy_done got=%b exp=10", {b1, dn1});
        end
        step();
        checks++;
        if ({b1, dn1} !== 2'b01) begin
            failures++;
            $display("FAIL d1_done busy_done got=%b exp=01", {b1, dn1});
        end
        checks++;
        if (fs1 !== exp) begin
            failures++;
            $display("FAIL d1_final got=%h exp=%h", fs1, exp);
        end
        step();
        checks++;
        if (dn1 !== 1'b0 || fs1 !== exp) begin
            failures++;
            $display("FAIL d1_hold done=%b final=%h exp done=0 final=%h", dn1, fs1, exp);
        end
    endtask

    task automatic test_d2();
        logic [N-1:0] exp;
        exp = bits3(66, 65, 62);
        sd2 = bits3(64, -1, -1);
        st2 = 1'b1;
        step();
        st2 = 1'b0;
        step();
        checks++;
        if ({b2, dn2} !== 2'b10) begin
            failures++;
            $display("FAIL d2_mid busy_done got=%b exp=10", {b2, dn2});
        end
        step();
        checks++;
        if ({b2, dn2} !== 2'b01 || fs2 !== exp) begin
            failures++;
            $display("FAIL d2_final busy_done=%b final=%h exp 01 %h", {b2, dn2}, fs2, exp);
        end
    endtask

    // Top and bottom edge seeds, the second start held through the done cycle.
    task automatic test_boundary_back_to_back();
        logic [N-1:0] exp_hi, exp_lo;
        exp_hi = bits3(N - 1, N - 2, -1);
        exp_lo = bits3(1, 0, -1);
        sd1 = bits3(N - 1, -1, -1);
        st1 = 1'b1;
        step();
        sd1 = bits3(0, -1, -1);
        step();
        checks++;
        if (dn1 !== 1'b1 || fs1 !== exp_hi) begin
            failures++;
            $display("FAIL edge_hi done=%b final=%h exp 1 %h", dn1, fs1, exp_hi);
        end
        step();
        st1 = 1'b0;
        checks++;
        if ({b1, dn1} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept busy_done got=%b exp=10", {b1, dn1});
        end
        step();
        checks++;
        if (dn1 !== 1'b1 || fs1 !== exp_lo) begin
            failures++;
            $display("FAIL edge_lo done=%b final=%h exp 1 %h", dn1, fs1, exp_lo);
        end
    endtask

    task automatic test_d0();
        logic [N-1:0] a;
        a = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
        sd0 = a;
        st0 = 1'b1;
        step();
        st0 = 1'b0;
        checks++;
        if ({b0, dn0} !== 2'b01 || fs0 !== a) begin
            failures++;
            $display("FAIL d0_pass busy_done=%b final=%h exp 01 %h", {b0, dn0}, fs0, a);
        end
        step();
        checks++;
        if (dn0 !== 1'b0 || fs0 !== a) begin
            failures++;
            $display("FAIL d0_hold done=%b final=%h exp 0 %h", dn0, fs0, a);
        end
    endtask

    task automatic test_long_zero();
        int lat, busy_cnt;
        lat = -1;
        busy_cnt = 0;
        sd256 = '0;
        st256 = 1'b1;
        step();
        st256 = 1'b0;
        if (b256) busy_cnt++;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (dn256) begin
                lat = c;
                break;
            end
            if (b256) busy_cnt++;
        end
        checks++;
        if (lat != 256) begin
            failures++;
            $display("FAIL zero_latency got=%0d exp=256", lat);
        end
        checks++;
        if (busy_cnt != 256) begin
            failures++;
            $display("FAIL zero_busy_cycles got=%0d exp=256", busy_cnt);
        end
        checks++;
        if (fs256 !== '0 || b256 !== 1'b0) begin
            failures++;
            $display("FAIL zero_final final=%h busy=%b exp 0 0", fs256, b256);
        end
    endtask

    task automatic test_ignore_start();
        logic [N-1:0] a, exp;
        int lat;
        a   = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
        exp = gold(a, 256);
        lat = -1;
        sd256 = a;
        st256 = 1'b1;
        step();
        st256 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == 10) begin
                sd256 = ~a;
                st256 = 1'b1;
            end else begin
                st256 = 1'b0;
            end
            step();
            if (dn256) begin
                lat = c;
                break;
            end
        end
        st256 = 1'b0;
        checks++;
        if (lat != 256) begin
            failures++;
            $display("FAIL busy_start_latency got=%0d exp=256", lat);
        end
        checks++;
        if (fs256 !== exp) begin
            failures++;
            $display("FAIL busy_start_final got=%h exp=%h", fs256, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] c_seed, d_seed, exp;
        int lat, stray;
        c_seed = {32'h0f0f0f0f, 32'h12345678, 32'h00000000, 32'h80000001};
        d_seed = {32'h00000000, 32'h00010000, 32'h00000000, 32'h00000000};
        exp    = gold(d_seed, 256);
        stray  = 0;
        lat    = -1;
        sd256 = c_seed;
        st256 = 1'b1;
        step();
        st256 = 1'b0;
        for (int c = 1; c < 50; c++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (fs256 !== '0 || b256 !== 1'b0 || dn256 !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset final=%h busy=%b done=%b exp 0 0 0", fs256, b256, dn256);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (dn256) stray++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 260; c++) begin
            step();
            if (dn256 || b256) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midrun_no_done got=%0d stray cycles exp=0", stray);
        end
        sd256 = d_seed;
        st256 = 1'b1;
        step();
        st256 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (dn256) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat != 256 || fs256 !== exp) begin
            failures++;
            $display("FAIL after_reset_run lat=%0d final=%h exp 256 %h", lat, fs256, exp);
        end
    endtask

    initial begin
        test_reset();
        test_d1();
        test_d2();
        test_boundary_back_to_back();
        test_d0();
        test_long_zero();
        test_ignore_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/r30_field.md
R30_FIELD -- requirements
Module: r30_field

Interface
REQ-001 The block SHALL have parameter N, default 128, the cell count (state width in bits, N >= 3).
REQ-002 The block SHALL have parameter D, default 256, the number of Rule 30 generations applied per run (D >= 0).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port clk, input, 1, rising-edge clock for all state.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start, input, 1, run request, sampled on the rising edge of clk.
REQ-007 Port seed, input, N, initial generation, captured when start is accepted.
REQ-008 Port final_state, output, N, registered result after D generations.
REQ-009 Port busy, output, 1, high while a run is in progress.
REQ-010 Port done, output, 1, single-cycle pulse marking final_state as newly valid.

Function
REQ-011 The next-state rule SHALL be Rule 30: new[i] = L XOR (C OR R), with C = s[i], L = s[i+1] (higher index), R = s[i-1] (lower index).
REQ-012 Boundaries SHALL be fixed at zero: s[N] and s[-1] read as 0. There SHALL be no wrap-around.
REQ-013 start SHALL be accepted only when busy = 0. start while busy = 1 SHALL be ignored, and seed SHALL NOT be sampled.
REQ-014 On the accepting edge k, the internal state SHALL load seed, the generation counter SHALL load D, and busy SHALL go high (D > 0).
REQ-015 Each of edges k+1 .. k+D SHALL apply exactly one generation to the state and decrement the counter.
REQ-016 On edge k+D, the D-th generation SHALL be written to both the state and final_state, done SHALL be 1 for that one cycle, and busy SHALL return to 0.
REQ-017 Run latency SHALL be exactly D cycles from the accepting edge to done.
REQ-018 For D = 0: on edge k, final_state SHALL become seed, done SHALL pulse, and busy SHALL stay 0.
REQ-019 final_state SHALL hold its value between runs and SHALL change only at a done edge or on reset.
REQ-020 start asserted in the done cycle SHALL be accepted, allowing back-to-back runs.
REQ-021 The counter width SHALL be clog2(D+1) bits, minimum 1.

Reset
REQ-022 While rst_n = 0: state, final_state and counter SHALL be all zeros, and busy and done SHALL be 0.
REQ-023 Reset asserted mid-run SHALL abort the run with no done pulse. After release, the block SHALL be idle awaiting start.

Structure
REQ-024 The Rule 30 rule SHALL be a purely combinational sub-module r30_step with parameter N, input cur[N-1:0] and output nxt[N-1:0], instantiated once.
REQ-025 The shared package SHALL contain only the zero-boundary constant and a clog2-style width helper. No typedefs are needed.
REQ-026 All sequential logic (state register, counter, busy, done, final_state) SHALL reside in r30_field.

Verification
REQ-027 N=128, D=1, seed = bit 64 only -> after 1 cycle, done=1 and final_state has bits 65, 64, 63 set, all others 0.
REQ-028 N=128, D=2, seed = bit 64 only -> after 2 cycles, done=1 and final_state has bits 66, 65, 62 set, all others 0.
REQ-029 D=1, seed = bit N-1 only -> final_state = bits N-1, N-2. D=1, seed = bit 0 only -> final_state = bits 1, 0. This checks the zero boundaries.
REQ-030 D=256, seed = 0 -> done exactly 256 cycles after start, final_state = 0, and busy high for exactly those 256 cycles.
REQ-031 Start a D=256 run, pulse start again at cycle 10 with a different seed -> the second start is ignored, and the result matches a golden model of the first seed.
REQ-032 Start a run, drop rst_n at cycle 50 -> outputs are 0 immediately and no done pulse occurs. A new start after release completes normally, with the result matching the golden model.
